// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the fetch stage: default widths, the reset fetch
//   address, the sequencer state encoding, and the sequential PC increment.
//   Also holds a small saturating-increment helper for the 16-bit counters.
package fetch_pkg;

   localparam int              PC_W     = 16;
   localparam int              INSN_W   = 16;
   localparam logic [15:0]     RESET_PC = 16'h0000;
   localparam int              PC_STEP  = 2;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   // Sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid
//   One-entry skid store for the instruction presented to decode. While decode
//   stalls, the memory output moves on to the next address, so the first
//   stalled word is captured here and selected in place of the live data.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   capture    presented instruction was not accepted this cycle
//   clear      presented instruction moves on (advance, redirect or halt)
//   d          live memory read data
//   q_sel_out  instruction to present: held word if one is stored, else d
module fetch_skid #(
   parameter int INSN_W = fetch_pkg::INSN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic              clear,
   input  logic [INSN_W-1:0] d,
   output logic [INSN_W-1:0] q_sel_out
);

   logic              hold_valid;
   logic [INSN_W-1:0] hold_ir;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, regardless of the order statements appear in.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_valid <= 1'b0;
         hold_ir    <= '0;
      end else if (clear) begin
         hold_valid <= 1'b0;
      end else if (capture && !hold_valid) begin
         // Only the first stalled cycle holds the correct word; later cycles
         // already show the next instruction on d.
         hold_ir    <= d;
         hold_valid <= 1'b1;
      end
   end

   assign q_sel_out = hold_valid ? hold_ir : d;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Drives the PC / instruction-memory side of fetch and presents one
//   instruction per cycle to decode with a valid/stall handshake.
//   Next-address priority: redirect > halt > stall > sequential (+2).
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   stall                       decode cannot take the presented instruction
//   redirect_valid/redirect_pc  taken branch/jump target from execute
//   halt                        stop fetching until reset
//   imem_addr/imem_en/ir_in     synchronous-read memory, 1-cycle latency
//   if_valid/if_ir/if_pc/if_pcp2  presented instruction, address, address+2
//   flush                       one-cycle pulse after an accepted redirect
//   misaligned                  sticky: a redirect target had bit 0 set
//   halted                      sequencer is in HALT
//   fetch_count                 accepted instructions (wraps)
//   stall_cycles                cycles with if_valid && stall (saturates)
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC = fetch_pkg::RESET_PC,
   parameter int          PC_W     = fetch_pkg::PC_W,
   parameter int          INSN_W   = fetch_pkg::INSN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_en,
   input  logic [INSN_W-1:0] ir_in,
   output logic              if_valid,
   output logic [INSN_W-1:0] if_ir,
   output logic [PC_W-1:0]   if_pc,
   output logic [PC_W-1:0]   if_pcp2,
   output logic              flush,
   output logic              misaligned,
   output logic              halted,
   output logic [15:0]       fetch_count,
   output logic [15:0]       stall_cycles
);

   import fetch_pkg::*;

   localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);
   localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);

   fetch_state_t      state;
   logic [PC_W-1:0]   pc_q;
   logic              inflight_valid;
   logic [PC_W-1:0]   inflight_pc;
   logic              advance;
   logic              accept;

   assign imem_addr = pc_q;
   assign imem_en   = (state == RUN);

   assign if_valid  = inflight_valid && (state == RUN);
   assign if_pc     = inflight_pc;
   assign if_pcp2   = inflight_pc + STEP;

   // A missing instruction never blocks the pipe; only a valid, stalled one does.
   assign advance   = !(if_valid && stall);
   assign accept    = if_valid && !stall;

   // Redirect and halt discard the presented instruction, so they also empty
   // the skid store; clear wins over capture inside the skid.
   fetch_skid #(.INSN_W(INSN_W)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .capture   (!advance),
      .clear     (redirect_valid || halt || advance),
      .d         (ir_in),
      .q_sel_out (if_ir)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= RUN;
         halted         <= 1'b0;
         pc_q           <= START_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
         flush          <= 1'b0;
         misaligned     <= 1'b0;
         fetch_count    <= '0;
         stall_cycles   <= '0;
      end else begin
         flush <= redirect_valid;

         if (accept) begin
            fetch_count <= fetch_count + 16'd1;
         end
         if (if_valid && stall) begin
            stall_cycles <= sat_inc16(stall_cycles);
         end

         if (redirect_valid) begin
            // Fetch is halfword-aligned; drop bit 0 and remember the fault.
            pc_q           <= {redirect_pc[PC_W-1:1], 1'b0};
            inflight_valid <= 1'b0;
            if (redirect_pc[0]) begin
               misaligned <= 1'b1;
            end
         end else if (state == RUN) begin
            if (halt) begin
               state          <= HALT;
               halted         <= 1'b1;
               inflight_valid <= 1'b0;
            end else if (advance) begin
               inflight_pc    <= pc_q;
               inflight_valid <= 1'b1;
               pc_q           <= pc_q + STEP;
            end
            // Stalled: pc_q keeps the next address on the memory, so ir_in is
            // already the following instruction when the stall releases.
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Self-checking bench. A behavioural memory returns addr ^ 16'hA5A5, so any
//   presented instruction must equal its own address ^ A5A5. A reference model
//   tracks the instruction stream (presented address, next address, flags,
//   counters) at the level of the fetch rules, with no skid-store detail.
module tb_fetch_sequencer;

   localparam logic [15:0] KEY = 16'hA5A5;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;
   logic [15:0] imem_addr;
   logic        imem_en;
   logic [15:0] ir_in = 16'h0000;
   logic        if_valid;
   logic [15:0] if_ir;
   logic [15:0] if_pc;
   logic [15:0] if_pcp2;
   logic        flush;
   logic        misaligned;
   logic        halted;
   logic [15:0] fetch_count;
   logic [15:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   fetch_sequencer #(.RESET_PC(16'h0000), .PC_W(16), .INSN_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_addr      (imem_addr),
      .imem_en        (imem_en),
      .ir_in          (ir_in),
      .if_valid       (if_valid),
      .if_ir          (if_ir),
      .if_pc          (if_pc),
      .if_pcp2        (if_pcp2),
      .flush          (flush),
      .misaligned     (misaligned),
      .halted         (halted),
      .fetch_count    (fetch_count),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory, one cycle of latency.
   always @(posedge clk) begin
      if (imem_en) ir_in <= imem_addr ^ KEY;
   end

   // Reference model state
   logic        m_valid;
   logic [15:0] m_pc;
   logic [15:0] m_next;
   logic        m_flush;
   logic        m_mis;
   logic        m_halt;
   logic [15:0] m_fc;
   logic [15:0] m_sc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_pc    = 16'h0000;
      m_next  = 16'h0000;
      m_flush = 1'b0;
      m_mis   = 1'b0;
      m_halt  = 1'b0;
      m_fc    = 16'h0000;
      m_sc    = 16'h0000;
   endtask

   // Applies one clock edge of the fetch rules using the inputs held at the edge.
   task automatic model_edge();
      if (m_valid && !stall) m_fc = m_fc + 16'd1;
      if (m_valid && stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      m_flush = redirect_valid;
      if (redirect_valid) begin
         m_next  = redirect_pc & 16'hFFFE;
         m_valid = 1'b0;
         if (redirect_pc[0]) m_mis = 1'b1;
      end else if (!m_halt) begin
         if (halt) begin
            m_halt  = 1'b1;
            m_valid = 1'b0;
         end else if (!(m_valid && stall)) begin
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = m_next + 16'd2;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".if_valid"},   {31'd0, if_valid},     {31'd0, m_valid});
      check({tag, ".imem_addr"},  {16'd0, imem_addr},    {16'd0, m_next});
      check({tag, ".imem_en"},    {31'd0, imem_en},      {31'd0, !m_halt});
      check({tag, ".if_pc"},      {16'd0, if_pc},        {16'd0, m_pc});
      check({tag, ".if_pcp2"},    {16'd0, if_pcp2},      {16'd0, m_pc + 16'd2});
      check({tag, ".flush"},      {31'd0, flush},        {31'd0, m_flush});
      check({tag, ".misaligned"}, {31'd0, misaligned},   {31'd0, m_mis});
      check({tag, ".halted"},     {31'd0, halted},       {31'd0, m_halt});
      check({tag, ".fetch_cnt"},  {16'd0, fetch_count},  {16'd0, m_fc});
      check({tag, ".stall_cyc"},  {16'd0, stall_cycles}, {16'd0, m_sc});
      if (m_valid) check({tag, ".if_ir"}, {16'd0, if_ir}, {16'd0, m_pc ^ KEY});
   endtask

   task automatic idle_inputs();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      halt           = 1'b0;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   // Assert reset off the clock edge, check reset values, then release it.
   task automatic do_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      compare_all("reset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      compare_all("cycle0");
   endtask

   task automatic redirect_to(input logic [15:0] target, input logic with_stall);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      stall          = with_stall;
      step("redir");
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      model_reset();
      #1;
      do_reset();

      // Sequential flow from reset
      check("cycle0.imem_addr", {16'd0, imem_addr}, 32'h0000);
      for (int i = 0; i < 3; i++) step("seq");
      check("seq.if_pc_is_4",  {16'd0, if_pc},       32'h0004);
      check("seq.count_is_2",  {16'd0, fetch_count}, 32'h0002);

      // Stall three cycles at 0004, then release
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step("stall");
      check("stall.ir_held",   {16'd0, if_ir},        {16'd0, 16'h0004 ^ KEY});
      check("stall.addr_held", {16'd0, imem_addr},    32'h0006);
      check("stall.cycles_3",  {16'd0, stall_cycles}, 32'h0003);
      stall = 1'b0;
      step("release");
      check("release.if_pc",   {16'd0, if_pc},        32'h0006);
      step("release2");
      check("release2.if_pc",  {16'd0, if_pc},        32'h0008);

      // Redirect overrides stall; one bubble
      redirect_to(16'h0120, 1'b1);
      check("redir.flush",     {31'd0, flush},        32'd1);
      check("redir.addr",      {16'd0, imem_addr},    32'h0120);
      step("redir_next");
      check("redir.if_pc",     {16'd0, if_pc},        32'h0120);

      // Misaligned target
      redirect_to(16'h0033, 1'b0);
      check("mis.addr",        {16'd0, imem_addr},    32'h0032);
      check("mis.flag",        {31'd0, misaligned},   32'd1);
      step("mis_next");

      // Wrap at top of address space
      redirect_to(16'hFFFC, 1'b0);
      step("wrap1");
      step("wrap2");
      check("wrap.if_pc",      {16'd0, if_pc},        32'hFFFE);
      check("wrap.if_pcp2",    {16'd0, if_pcp2},      32'h0000);
      check("wrap.addr",       {16'd0, imem_addr},    32'h0000);

      // Randomized stall / redirect traffic
      for (int i = 0; i < 400; i++) begin
         stall          = ($urandom_range(9) < 3);
         redirect_valid = ($urandom_range(15) == 0);
         redirect_pc    = 16'($urandom);
         halt           = 1'b0;
         step("rand");
      end
      idle_inputs();
      step("rand_end");

      // Redirect beats halt in the same cycle
      halt = 1'b1;
      redirect_to(16'h0200, 1'b0);
      check("halt_vs_redir.halted", {31'd0, halted}, 32'd0);
      step("post_redir");

      // Halt, then stay halted with random stall
      halt = 1'b1;
      step("halt");
      check("halt.halted",  {31'd0, halted},   32'd1);
      check("halt.imem_en", {31'd0, imem_en},  32'd0);
      check("halt.valid",   {31'd0, if_valid}, 32'd0);
      halt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         stall = $urandom_range(1);
         step("halted");
      end
      idle_inputs();

      // Reset mid-stall clears everything immediately
      do_reset();
      for (int i = 0; i < 4; i++) step("run2");
      stall = 1'b1;
      step("stall2");
      step("stall2");
      do_reset();
      check("rst.stall_cycles", {16'd0, stall_cycles}, 32'h0000);
      check("rst.if_pcp2",      {16'd0, if_pcp2},      32'h0002);
      idle_inputs();
      for (int i = 0; i < 3; i++) step("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
